// File: rtl/inst_cache.sv
// Direct-mapped, one-word-per-line instruction cache. Hits return in the cycle after lookup;
// misses refill the line byte-serially over the shared 8-bit memory port.
module inst_cache #(
  parameter int ADDR_W = 32,
  parameter int LINES  = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_pc,
  input  logic              flush,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_grant,
  input  logic [7:0]        mem_din,
  output logic              inst_valid,
  output logic [31:0]       inst_o,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              hit,
  output logic              busy
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOOKUP = 2'd1;
  localparam logic [1:0] S_FILL   = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]        state;
  logic [ADDR_W-1:0] pc_q;
  logic [2:0]        issue;
  logic [2:0]        recv;
  logic              in_flight;
  logic [3:0][7:0]   fill_q;
  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [31:0]       data_mem [LINES];

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic              lookup_hit;

  assign idx        = pc_q[IDX_W+1:2];
  assign tag        = pc_q[ADDR_W-1:IDX_W+2];
  assign lookup_hit = valid_q[idx] && (tag_mem[idx] == tag);

  // Request and address follow the held state/counters, so a rdy freeze holds them too.
  assign mem_req  = (state == S_FILL) && !issue[2];
  assign mem_addr = mem_req ? pc_q + {{(ADDR_W-3){1'b0}}, issue} : '0;
  assign busy     = (state != S_IDLE);

  // NOTE: every register here uses non-blocking assignment so all updates see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      pc_q       <= '0;
      issue      <= '0;
      recv       <= '0;
      in_flight  <= 1'b0;
      fill_q     <= '0;
      valid_q    <= '0;
      inst_valid <= 1'b0;
      hit        <= 1'b0;
      inst_o     <= '0;
      inst_pc    <= '0;
    end else if (rdy) begin
      inst_valid <= 1'b0;
      hit        <= 1'b0;
      if (flush) begin
        state     <= S_IDLE;
        in_flight <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (fetch_req) begin
              pc_q  <= fetch_pc & {{(ADDR_W-2){1'b1}}, 2'b00};
              state <= S_LOOKUP;
            end
          end
          S_LOOKUP: begin
            if (lookup_hit) begin
              inst_valid <= 1'b1;
              hit        <= 1'b1;
              inst_o     <= data_mem[idx];
              inst_pc    <= pc_q;
              state      <= S_IDLE;
            end else begin
              issue     <= '0;
              recv      <= '0;
              in_flight <= 1'b0;
              state     <= S_FILL;
            end
          end
          S_FILL: begin
            // in_flight marks that mem_din carries the byte granted last cycle.
            in_flight <= mem_req && mem_grant;
            if (mem_req && mem_grant) issue <= issue + 3'd1;
            if (in_flight) begin
              fill_q[recv[1:0]] <= mem_din;
              recv              <= recv + 3'd1;
              if (recv == 3'd3) begin
                inst_valid <= 1'b1;
                inst_o     <= {mem_din, fill_q[2], fill_q[1], fill_q[0]};
                inst_pc    <= pc_q;
                state      <= S_DONE;
              end
            end
          end
          S_DONE: begin
            valid_q[idx] <= 1'b1;
            state        <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // NOTE: tag/data arrays have no reset; valid_q alone decides whether their contents count.
  always_ff @(posedge clk) begin
    if (!rst && rdy && !flush && state == S_DONE) begin
      data_mem[idx] <= fill_q;
      tag_mem[idx]  <= tag;
    end
  end

endmodule

// File: tb/tb_inst_cache.sv
// Scoreboard bench for inst_cache: stimulus queues expected words and byte addresses,
// monitors compare whenever the DUT grants a byte or pulses inst_valid.
module tb_inst_cache;

  logic        clk = 1'b0;
  logic        rst, rdy, fetch_req, flush;
  logic [31:0] fetch_pc;
  logic        mem_req, mem_grant;
  logic [31:0] mem_addr;
  logic [7:0]  mem_din = '0;
  logic        inst_valid, hit, busy;
  logic [31:0] inst_o, inst_pc;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
    logic        hit;
    int          due;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] addr_q[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          req_cycles = 0;
  int          s;
  logic [7:0]  mem [4096];
  logic        toggle_mode;
  logic        gtog = 1'b1;

  inst_cache #(.ADDR_W(32), .LINES(128)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .fetch_req(fetch_req), .fetch_pc(fetch_pc),
    .flush(flush), .mem_req(mem_req), .mem_addr(mem_addr), .mem_grant(mem_grant),
    .mem_din(mem_din), .inst_valid(inst_valid), .inst_o(inst_o), .inst_pc(inst_pc),
    .hit(hit), .busy(busy)
  );

  always #5 clk = ~clk;

  // Arbiter/memory model: grants are frozen with rdy; toggle mode grants every other request cycle.
  assign mem_grant = rdy && mem_req && (!toggle_mode || gtog);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!mem_req) gtog <= 1'b1;
    else if (rdy) gtog <= ~gtog;
    if (mem_grant) mem_din <= mem[mem_addr[11:0]];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors sample 2 time units after the falling edge, after stimulus has settled.
  always @(negedge clk) begin : monitor
    exp_t e;
    #2;
    if (!rst && inst_valid) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_inst_valid: pc %h word %h, none expected", inst_pc, inst_o);
      end else begin
        e = exp_q.pop_front();
        check("inst_pc", inst_pc, e.pc);
        check("inst_o", inst_o, e.word);
        check("hit", {31'b0, hit}, {31'b0, e.hit});
        check("latency_cycle", cyc, e.due);
      end
    end
    if (!rst && mem_grant) begin
      if (addr_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_grant: mem_addr %h, none expected", mem_addr);
      end else begin
        check("mem_addr", mem_addr, addr_q.pop_front());
      end
    end
    if (mem_req) req_cycles++;
  end

  task automatic wait_idle();
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      tests++;
      fails++;
      $display("FAIL idle_timeout: busy=%b pending=%0d at cycle %0d", busy, exp_q.size(), cyc);
      exp_q.delete();
      addr_q.delete();
    end
  endtask

  task automatic do_fetch(input logic [31:0] pc, input logic [31:0] word, input logic h,
                          input int lat);
    wait_idle();
    fetch_req = 1'b1;
    fetch_pc  = pc;
    exp_q.push_back('{pc, word, h, cyc + lat});
    if (!h) for (int i = 0; i < 4; i++) addr_q.push_back(pc + 32'(i));
    @(negedge clk);
    fetch_req = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; fetch_req = 1'b0; fetch_pc = '0; flush = 1'b0; toggle_mode = 1'b0;
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    mem[12'h000] = 8'h13; mem[12'h001] = 8'h05; mem[12'h002] = 8'h00; mem[12'h003] = 8'h00;
    mem[12'h200] = 8'h93; mem[12'h201] = 8'h00; mem[12'h202] = 8'h10; mem[12'h203] = 8'h00;
    mem[12'h010] = 8'hb3; mem[12'h011] = 8'h01; mem[12'h012] = 8'h31; mem[12'h013] = 8'h00;
    mem[12'h040] = 8'h6f; mem[12'h041] = 8'h00; mem[12'h042] = 8'h80; mem[12'h043] = 8'h00;
    mem[12'h080] = 8'h23; mem[12'h081] = 8'ha0; mem[12'h082] = 8'h52; mem[12'h083] = 8'h00;

    repeat (3) @(negedge clk);
    check("rst_mem_req", {31'b0, mem_req}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    check("rst_inst_o", inst_o, 32'd0);
    check("rst_inst_pc", inst_pc, 32'd0);
    check("rst_hit", {31'b0, hit}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    rst = 1'b0;

    // Cold miss, then hit on the same line with no memory traffic.
    do_fetch(32'h0, 32'h0000_0513, 1'b0, 7);
    wait_idle();
    req_cycles = 0;
    do_fetch(32'h0, 32'h0000_0513, 1'b1, 2);
    wait_idle();
    check("hit_mem_req_cycles", 32'(req_cycles), 32'd0);

    // Aliasing tag at index 0 evicts, so 0x0 misses again.
    do_fetch(32'h200, 32'h0010_0093, 1'b0, 7);
    do_fetch(32'h0, 32'h0000_0513, 1'b0, 7);

    // Flush after two grants: request drops, nothing delivered, line stays invalid.
    wait_idle();
    for (int i = 0; i < 3; i++) addr_q.push_back(32'h10 + 32'(i));
    fetch_req = 1'b1;
    fetch_pc  = 32'h10;
    @(negedge clk);
    fetch_req = 1'b0;
    repeat (3) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_mem_req", {31'b0, mem_req}, 32'd0);
    check("flush_busy", {31'b0, busy}, 32'd0);
    repeat (4) @(negedge clk);
    check("flush_addr_q_left", 32'(addr_q.size()), 32'd0);

    // fetch_req together with flush in IDLE is ignored.
    fetch_req = 1'b1;
    flush     = 1'b1;
    fetch_pc  = 32'h0;
    @(negedge clk);
    fetch_req = 1'b0;
    flush     = 1'b0;
    check("flush_fetch_ignored_busy", {31'b0, busy}, 32'd0);

    do_fetch(32'h10, 32'h0031_01b3, 1'b0, 7);
    do_fetch(32'h10, 32'h0031_01b3, 1'b1, 2);

    // Grant toggling 1,0,1,0: three extra cycles.
    wait_idle();
    toggle_mode = 1'b1;
    do_fetch(32'h40, 32'h0080_006f, 1'b0, 10);
    wait_idle();
    toggle_mode = 1'b0;
    do_fetch(32'h40, 32'h0080_006f, 1'b1, 2);

    // rdy low for 5 cycles after two grants: outputs hold, completion 5 cycles late.
    wait_idle();
    s = cyc;
    exp_q.push_back('{32'h80, 32'h0052_a023, 1'b0, s + 12});
    for (int i = 0; i < 4; i++) addr_q.push_back(32'h80 + 32'(i));
    fetch_req = 1'b1;
    fetch_pc  = 32'h80;
    @(negedge clk);
    fetch_req = 1'b0;
    repeat (3) @(negedge clk);
    rdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("freeze_mem_req", {31'b0, mem_req}, 32'd1);
      check("freeze_mem_addr", mem_addr, 32'h82);
      check("freeze_busy", {31'b0, busy}, 32'd1);
      check("freeze_inst_valid", {31'b0, inst_valid}, 32'd0);
    end
    rdy = 1'b1;
    do_fetch(32'h80, 32'h0052_a023, 1'b1, 2);
    do_fetch(32'h0, 32'h0000_0513, 1'b1, 2);

    wait_idle();
    repeat (2) @(negedge clk);
    check("addr_q_leftover", 32'(addr_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
